// File: rtl/userio_osd_spi_master.sv
// Byte-push SPI master for the OSD/user-IO slave: mode 3 bus (sck idles high,
// sdo changes on sck falling, both ends sample on sck rising), MSB first.
module userio_osd_spi_master #(
    parameter int DIV      = 4,
    parameter int CS_SETUP = 1,
    parameter int CS_GAP   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       _scs,
    output logic       sck,
    output logic       sdo,
    input  logic       sdi
);
    localparam int HCW = $clog2(DIV);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_LOW, S_HIGH, S_BYTE, S_HOLD, S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [HCW-1:0] hc_q, hc_d;
    logic [7:0]     ph_q, ph_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [6:0]     rxsh_q, rxsh_d;
    logic           last_q, last_d;
    logic           armed_q;
    logic           scs_q, scs_d;
    logic           sck_q, sck_d;
    logic           sdo_q, sdo_d;
    logic           rx_valid_q, rx_valid_d;
    logic [7:0]     rx_data_q, rx_data_d;
    logic           sdi_meta_q, sdi_sync_q;

    logic hc_wrap, timed, accept;

    assign hc_wrap  = (hc_q == HCW'(DIV - 1));
    assign timed    = (state_q != S_IDLE) && (state_q != S_BYTE);
    // armed_q keeps tx_ready low while reset is held and for the release edge
    assign tx_ready = armed_q && ((state_q == S_IDLE) || ((state_q == S_BYTE) && !last_q));
    assign accept   = tx_valid && tx_ready;

    assign busy     = !scs_q || (state_q == S_GAP);
    assign _scs     = scs_q;
    assign sck      = sck_q;
    assign sdo      = sdo_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

    always_comb begin
        state_d    = state_q;
        hc_d       = timed ? (hc_wrap ? '0 : hc_q + HCW'(1)) : '0;
        ph_d       = ph_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        rxsh_d     = rxsh_q;
        last_d     = last_q;
        scs_d      = scs_q;
        sck_d      = sck_q;
        sdo_d      = sdo_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shreg_d = tx_data;
                    last_d  = tx_last;
                    scs_d   = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (hc_wrap) begin
                    if (ph_q == 8'(CS_SETUP - 1)) begin
                        ph_d    = '0;
                        bit_d   = 3'd7;
                        sck_d   = 1'b0;
                        sdo_d   = shreg_q[7];
                        state_d = S_LOW;
                    end else begin
                        ph_d = ph_q + 8'd1;
                    end
                end
            end
            S_LOW: begin
                if (hc_wrap) begin
                    sck_d   = 1'b1;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                // sample on the last cycle so the synchronised sdi has settled
                if (hc_wrap) begin
                    rxsh_d  = {rxsh_q[5:0], sdi_sync_q};
                    shreg_d = {shreg_q[6:0], 1'b0};
                    if (bit_q != 3'd0) begin
                        bit_d   = bit_q - 3'd1;
                        sck_d   = 1'b0;
                        sdo_d   = shreg_q[6];
                        state_d = S_LOW;
                    end else begin
                        rx_data_d  = {rxsh_q, sdi_sync_q};
                        rx_valid_d = 1'b1;
                        state_d    = S_BYTE;
                    end
                end
            end
            S_BYTE: begin
                if (last_q) begin
                    state_d = S_HOLD;
                end else if (accept) begin
                    shreg_d = tx_data;
                    last_d  = tx_last;
                    bit_d   = 3'd7;
                    sck_d   = 1'b0;
                    sdo_d   = tx_data[7];
                    state_d = S_LOW;
                end
            end
            S_HOLD: begin
                if (hc_wrap) begin
                    scs_d   = 1'b1;
                    sdo_d   = 1'b0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (hc_wrap) begin
                    if (ph_q == 8'(CS_GAP - 1)) begin
                        ph_d    = '0;
                        state_d = S_IDLE;
                    end else begin
                        ph_d = ph_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hc_q       <= '0;
            ph_q       <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            rxsh_q     <= '0;
            last_q     <= 1'b0;
            armed_q    <= 1'b0;
            scs_q      <= 1'b1;
            sck_q      <= 1'b1;
            sdo_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            sdi_meta_q <= 1'b0;
            sdi_sync_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hc_q       <= hc_d;
            ph_q       <= ph_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            rxsh_q     <= rxsh_d;
            last_q     <= last_d;
            armed_q    <= 1'b1;
            scs_q      <= scs_d;
            sck_q      <= sck_d;
            sdo_q      <= sdo_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            sdi_meta_q <= sdi;
            sdi_sync_q <= sdi_meta_q;
        end
    end
endmodule

// File: tb/tb_userio_osd_spi_master.sv
// Bench: three master instances (DIV = 3, 4, 8), each driven independently and
// checked against a mode-3 slave model plus byte/timing scoreboards.
module tb_userio_osd_spi_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        localparam int D = (gi == 0) ? 3 : ((gi == 1) ? 4 : 8);

        logic       reset, tx_valid, tx_last, tx_ready, rx_valid, busy, scs, sck, sdo;
        logic       sdi = 1'b0;
        logic [7:0] tx_data, rx_data;
        logic       lane_done = 1'b0;
        logic       abort = 1'b0;

        userio_osd_spi_master #(.DIV(D), .CS_SETUP(1), .CS_GAP(2)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .tx_valid (tx_valid),
            .tx_data  (tx_data),
            .tx_last  (tx_last),
            .tx_ready (tx_ready),
            .rx_valid (rx_valid),
            .rx_data  (rx_data),
            .busy     (busy),
            ._scs     (scs),
            .sck      (sck),
            .sdo      (sdo),
            .sdi      (sdi)
        );

        logic [8:0] sent_q[$];   // {is_first_byte, data} in send order
        logic [7:0] resp_q[$];   // bytes the slave shifted out, in order
        logic [7:0] force_q[$];  // directed slave responses
        int fall_t = 0, last_rises = 0, nfall = 0, rxcnt = 0;

        // Slave: drives sdi on sck falling, captures sdo on sck rising.
        initial begin
            logic pscs, psck, first_b;
            logic [7:0] sin, sout;
            logic [8:0] e9;
            int sbit, rises;
            pscs = 1'b1; psck = 1'b1; first_b = 1'b0;
            sin = '0; sout = '0; sbit = 0; rises = 0;
            forever begin
                @(scs or sck);
                #1;
                if (pscs === 1'b1 && scs === 1'b0) begin
                    sbit = 0; first_b = 1'b1; rises = 0;
                end
                if (pscs === 1'b0 && scs === 1'b1 && !abort) begin
                    chk("scs_rise_on_byte_boundary", sbit, 0);
                    last_rises = rises;
                end
                if (scs === 1'b0 && psck === 1'b1 && sck === 1'b0) begin
                    if (sbit == 0) begin
                        if (force_q.size() != 0) sout = force_q.pop_front();
                        else sout = 8'($urandom);
                        resp_q.push_back(sout);
                        fall_t = cyc;
                    end
                    sdi = sout[7 - sbit];
                end
                if (scs === 1'b0 && psck === 1'b0 && sck === 1'b1 && !abort) begin
                    sin = {sin[6:0], sdo};
                    sbit++;
                    rises++;
                    if (sbit == 8) begin
                        sbit = 0;
                        if (sent_q.size() == 0) chk("slave_unexpected_byte", 1, 0);
                        else begin
                            e9 = sent_q.pop_front();
                            chk("slave_rx_byte", sin, e9[7:0]);
                            chk("slave_cmd_flag", first_b, e9[8]);
                        end
                        first_b = 1'b0;
                    end
                end
                pscs = scs; psck = sck;
            end
        end

        // Bus monitor, sampled on the falling clk edge.
        initial begin
            logic psck_m, pscs_m, pbusy_m, prxv_m, gap_armed;
            logic [7:0] e8;
            int lowcnt, last_rise_t, gap_start;
            psck_m = 1'b1; pscs_m = 1'b1; pbusy_m = 1'b0; prxv_m = 1'b0; gap_armed = 1'b0;
            lowcnt = 0; last_rise_t = 0; gap_start = 0;
            forever begin
                @(negedge clk);
                if (reset !== 1'b0) begin
                    lowcnt = 0; gap_armed = 1'b0;
                end else begin
                    if (!sck) lowcnt++;
                    if (sck && !psck_m) begin
                        chk("sck_low_len", lowcnt, D);
                        lowcnt = 0; last_rise_t = cyc;
                    end
                    if (!sck && psck_m) nfall++;
                    if (scs !== pscs_m) chk("scs_moves_only_with_sck_high", sck, 1);
                    if (scs && !pscs_m) begin
                        chk("cs_hold_ge_half_period", 32'((cyc - last_rise_t) >= D), 1);
                        gap_start = cyc; gap_armed = 1'b1;
                    end
                    if (!busy && pbusy_m && gap_armed) begin
                        chk("cs_gap_len", cyc - gap_start, 2 * D);
                        gap_armed = 1'b0;
                    end
                    if (!scs) chk("busy_while_selected", busy, 1);
                    if (!sck || (scs && busy)) chk("ready_low_in_timed_phase", tx_ready, 0);
                    if (rx_valid) begin
                        chk("rx_valid_single_cycle", prxv_m, 0);
                        chk("byte_time", cyc - fall_t, 16 * D);
                        if (resp_q.size() == 0) chk("rx_unexpected", 1, 0);
                        else begin
                            e8 = resp_q.pop_front();
                            chk("rx_data", rx_data, e8);
                        end
                        rxcnt++;
                        $display("DIV=%0d rx byte %02h", D, rx_data);
                    end
                end
                psck_m = sck; pscs_m = scs; pbusy_m = busy; prxv_m = rx_valid;
            end
        end

        task automatic send_byte(input logic [7:0] d, input logic l, input logic first, input bit keep);
            int t;
            t = 0;
            tx_valid = 1'b1; tx_data = d; tx_last = l;
            while (!tx_ready && t < 4000) begin @(negedge clk); t++; end
            if (t >= 4000) chk("accept_timeout", 0, 1);
            else begin
                sent_q.push_back({first, d});
                @(negedge clk);
            end
            if (!keep) tx_valid = 1'b0;
        endtask

        task automatic wait_idle();
            int t;
            t = 0;
            while (!(!busy && tx_ready) && t < 4000) begin @(negedge clk); t++; end
            if (t >= 4000) chk("idle_timeout", 0, 1);
        endtask

        task automatic wait_ready();
            int t;
            t = 0;
            while (!tx_ready && t < 4000) begin @(negedge clk); t++; end
            if (t >= 4000) chk("ready_timeout", 0, 1);
        endtask

        task automatic send_xfer(input int n, input bit hold, input int stall_max);
            for (int i = 0; i < n; i++) begin
                if (!hold) repeat ($urandom_range(stall_max, 0)) @(negedge clk);
                send_byte(8'($urandom), i == n - 1, i == 0, hold && (i != n - 1));
            end
            wait_idle();
        endtask

        initial begin
            int r0, bad, base, t;
            reset = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
            repeat (3) @(negedge clk);
            chk("rst_scs", scs, 1);
            chk("rst_sck", sck, 1);
            chk("rst_sdo", sdo, 0);
            chk("rst_tx_ready", tx_ready, 0);
            chk("rst_rx_valid", rx_valid, 0);
            chk("rst_rx_data", rx_data, 8'h00);
            chk("rst_busy", busy, 0);
            reset = 1'b0;
            @(negedge clk);
            chk("ready_after_release", tx_ready, 1);

            // single command byte, slave answers 0x3C
            force_q.push_back(8'h3C);
            send_byte(8'hA5, 1'b1, 1'b1, 1'b0);
            wait_idle();
            chk("t1_rx_data", rx_data, 8'h3C);

            // three-byte transfer, only the first is a command
            r0 = rxcnt;
            send_byte(8'h12, 1'b0, 1'b1, 1'b0);
            send_byte(8'h34, 1'b0, 1'b0, 1'b0);
            send_byte(8'h56, 1'b1, 1'b0, 1'b0);
            wait_idle();
            chk("t2_rx_pulses", rxcnt - r0, 3);
            chk("t2_rises_while_selected", last_rises, 24);

            // open transfer stalled for 100 cycles between bytes
            send_byte(8'hC3, 1'b0, 1'b1, 1'b0);
            wait_ready();
            bad = 0;
            repeat (100) begin
                @(negedge clk);
                if (sck !== 1'b1 || scs !== 1'b0 || tx_ready !== 1'b1) bad++;
            end
            chk("t3_stall_holds_bus", bad, 0);
            send_byte(8'h3C, 1'b1, 1'b0, 1'b0);
            wait_idle();

            // reset during the 4th sck low phase
            base = nfall;
            send_byte(8'hF0, 1'b1, 1'b1, 1'b0);
            t = 0;
            while (nfall < base + 4 && t < 4000) begin @(negedge clk); t++; end
            chk("t4_reached_4th_low", 32'(nfall >= base + 4), 1);
            abort = 1'b1; reset = 1'b1;
            @(negedge clk);
            chk("t4_scs", scs, 1);
            chk("t4_sck", sck, 1);
            chk("t4_sdo", sdo, 0);
            chk("t4_rx_valid", rx_valid, 0);
            sent_q.delete(); resp_q.delete();
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            abort = 1'b0;
            r0 = rxcnt;
            send_xfer(2, 1'b0, 3);
            chk("t4_after_reset_pulses", rxcnt - r0, 2);

            // tx_valid held high for the whole transfer
            r0 = rxcnt;
            send_xfer(3, 1'b1, 0);
            chk("t5_one_accept_per_slot", rxcnt - r0, 3);
            chk("t5_no_leftover_bytes", sent_q.size(), 0);

            // random traffic
            for (int k = 0; k < 12; k++)
                send_xfer($urandom_range(4, 1), 1'($urandom_range(1, 0)), 12);
            chk("rand_all_bytes_seen", sent_q.size(), 0);
            chk("rand_all_resp_seen", resp_q.size(), 0);
            lane_done = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_lane[0].lane_done && g_lane[1].lane_done && g_lane[2].lane_done) && t < 60000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60000) chk("global_timeout", 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
